// File: rtl/sar_search_ctrl.sv
// rtl/sar_search_ctrl.sv - successive-approximation search controller driving a magnitude comparator
// Optional one-hot flag checking with err output: define SAR_ONEHOT_CHECK_EN.
module sar_search_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH:0]   probes
`ifdef SAR_ONEHOT_CHECK_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [WIDTH:0]   ONE        = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   HI_INIT    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] GUESS_INIT = {1'b0, {(WIDTH-1){1'b1}}};

    state_t           state, state_nxt;
    logic [WIDTH:0]   lo, lo_nxt;
    logic [WIDTH:0]   hi, hi_nxt;
    logic [WIDTH-1:0] guess_nxt;
    logic             found_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic [WIDTH:0]   probes_nxt;
    logic [WIDTH:0]   guess_ext;
    logic [WIDTH:0]   guess_inc;
    logic [WIDTH:0]   guess_dec;
    logic             flag_bad;
`ifdef SAR_ONEHOT_CHECK_EN
    logic             err_nxt;
`endif

    // Sum is taken one bit wider than the bounds so lo+hi never wraps.
    function automatic logic [WIDTH+1:0] mid(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        logic [WIDTH+1:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s >> 1;
    endfunction

    assign guess_ext = {1'b0, guess};
    assign guess_inc = guess_ext + ONE;
    assign guess_dec = guess_ext - ONE;

    assign busy = (state == SEARCH);
    assign done = (state == DONE);

`ifdef SAR_ONEHOT_CHECK_EN
    assign flag_bad = !(({gt, eq, lt} == 3'b100) || ({gt, eq, lt} == 3'b010) ||
                        ({gt, eq, lt} == 3'b001));
`else
    assign flag_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            lo     <= '0;
            hi     <= '0;
            guess  <= '0;
            found  <= 1'b0;
            result <= '0;
            probes <= '0;
`ifdef SAR_ONEHOT_CHECK_EN
            err    <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            lo     <= lo_nxt;
            hi     <= hi_nxt;
            guess  <= guess_nxt;
            found  <= found_nxt;
            result <= result_nxt;
            probes <= probes_nxt;
`ifdef SAR_ONEHOT_CHECK_EN
            err    <= err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        lo_nxt     = lo;
        hi_nxt     = hi;
        guess_nxt  = guess;
        found_nxt  = found;
        result_nxt = result;
        probes_nxt = probes;
`ifdef SAR_ONEHOT_CHECK_EN
        err_nxt    = err;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = SEARCH;
                    lo_nxt     = '0;
                    hi_nxt     = HI_INIT;
                    guess_nxt  = GUESS_INIT;
                    probes_nxt = '0;
                    found_nxt  = 1'b0;
`ifdef SAR_ONEHOT_CHECK_EN
                    err_nxt    = 1'b0;
`endif
                end
            end
            SEARCH: begin
                probes_nxt = probes + ONE;
                if (flag_bad) begin
`ifdef SAR_ONEHOT_CHECK_EN
                    err_nxt    = 1'b1;
`endif
                    found_nxt  = 1'b0;
                    result_nxt = '0;
                    state_nxt  = DONE;
                end else if (eq) begin
                    result_nxt = guess;
                    found_nxt  = 1'b1;
                    state_nxt  = DONE;
                end else if (gt) begin
                    if (guess_inc > hi) begin
                        found_nxt  = 1'b0;
                        result_nxt = '0;
                        state_nxt  = DONE;
                    end else begin
                        lo_nxt    = guess_inc;
                        guess_nxt = WIDTH'(mid(guess_inc, hi));
                    end
                end else begin
                    // LT, and also the all-zero flag case when checking is off.
                    if (guess == '0 || guess_dec < lo) begin
                        found_nxt  = 1'b0;
                        result_nxt = '0;
                        state_nxt  = DONE;
                    end else begin
                        hi_nxt    = guess_dec;
                        guess_nxt = WIDTH'(mid(lo, guess_dec));
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb/tb_sar_search_ctrl.sv - table-driven scoreboard bench for sar_search_ctrl
module tb_sar_search_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       gt, eq, lt;
    logic [2:0] guess;
    logic       busy, done, found;
    logic [2:0] result;
    logic [3:0] probes;
`ifdef SAR_ONEHOT_CHECK_EN
    logic       err;
`endif

    int target;
    int mode;    // 0 = comparator model, 1 = all flags low, 2 = gt and eq both high
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int              target;
        int              mode;
        bit              hold;
        int              nseq;
        logic [3:0][2:0] seq;
        logic [2:0]      res;
        logic            found;
        logic [3:0]      probes;
        logic            err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    sar_search_ctrl #(.WIDTH(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .gt     (gt),
        .eq     (eq),
        .lt     (lt),
        .guess  (guess),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .result (result),
        .probes (probes)
`ifdef SAR_ONEHOT_CHECK_EN
        ,
        .err    (err)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        gt = 1'b0;
        eq = 1'b0;
        lt = 1'b0;
        case (mode)
            1: ;
            2: begin
                gt = 1'b1;
                eq = 1'b1;
            end
            default: begin
                gt = (target > int'(guess));
                eq = (target == int'(guess));
                lt = (target < int'(guess));
            end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int t, input int m, input bit h, input int n,
                                input int s0, input int s1, input int s2, input int s3,
                                input int r, input bit f, input int p, input bit e);
        vec_t v;
        v.target = t;
        v.mode   = m;
        v.hold   = h;
        v.nseq   = n;
        v.seq[0] = 3'(s0);
        v.seq[1] = 3'(s1);
        v.seq[2] = 3'(s2);
        v.seq[3] = 3'(s3);
        v.res    = 3'(r);
        v.found  = f;
        v.probes = 4'(p);
        v.err    = e;
        return v;
    endfunction

    task automatic run(input vec_t v);
        vec_t e;
        int   n;
        bit   seen;
        target = v.target;
        mode   = v.mode;
        start  = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        if (!v.hold) start = 1'b0;
        n    = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) begin
                if (n < v.nseq) chk("guess_seq", 32'(guess), 32'(v.seq[n]));
                n++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        e = exp_q.pop_front();
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("result", 32'(result), 32'(e.res));
            chk("found", 32'(found), 32'(e.found));
            chk("probes", 32'(probes), 32'(e.probes));
            chk("busy_at_done", 32'(busy), 0);
            chk("latency", n, 32'(e.probes));
`ifdef SAR_ONEHOT_CHECK_EN
            chk("err", 32'(err), 32'(e.err));
`endif
        end
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("found_held", 32'(found), 32'(e.found));
    endtask

    initial begin
        int exh_probes[8];
        exh_probes = '{3, 2, 3, 1, 3, 2, 3, 4};

        tbl.push_back(mk(5, 0, 0, 2, 3, 5, 0, 0, 5, 1, 2, 0));
        tbl.push_back(mk(7, 0, 0, 4, 3, 5, 6, 7, 7, 1, 4, 0));
        tbl.push_back(mk(0, 0, 0, 3, 3, 1, 0, 0, 0, 1, 3, 0));
`ifdef SAR_ONEHOT_CHECK_EN
        tbl.push_back(mk(5, 1, 0, 1, 3, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(6, 2, 0, 1, 3, 0, 0, 0, 0, 0, 1, 1));
`else
        tbl.push_back(mk(5, 1, 0, 3, 3, 1, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(6, 2, 0, 1, 3, 0, 0, 0, 3, 1, 1, 0));
`endif
        for (int t = 0; t < 8; t++)
            tbl.push_back(mk(t, 0, 1, 0, 0, 0, 0, 0, t, 1, exh_probes[t], 0));

        target = 0;
        mode   = 0;
        start  = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_guess", 32'(guess), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_found", 32'(found), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_probes", 32'(probes), 0);
`ifdef SAR_ONEHOT_CHECK_EN
        chk("rst_err", 32'(err), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) run(tbl[i]);

        // Reset in the middle of a T=6 search, right after the second probe.
        target = 6;
        mode   = 0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", 32'(busy), 1);
        chk("mid_guess", 32'(guess), 6);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_guess", 32'(guess), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(done), 0);
        chk("mrst_found", 32'(found), 0);
        chk("mrst_result", 32'(result), 0);
        chk("mrst_probes", 32'(probes), 0);
        @(negedge clk);
        chk("mrst_idle", 32'(busy), 0);
        run(mk(6, 0, 0, 3, 3, 5, 6, 0, 6, 1, 3, 0));

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
